pixel_stream_reader: RTL and testbench



---
 rtl/pixel_stream_reader_pkg.sv | 19 +
 rtl/pixel_stream_reader_syncskidbuffer.sv | 58 +++++
 rtl/pixel_stream_reader.sv | 161 ++++++++++++++++
 tb/tb_pixel_stream_reader.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_reader_pkg.sv
// Shared video definitions: reader FSM encoding, default 320x240 geometry,
// and the counter width helper used to size every counter from parameters.
package pixel_stream_reader_pkg;

  typedef enum logic [1:0] {
    sIdle  = 2'd0,
    sRun   = 2'd1,
    sDrain = 2'd2
  } stateT;

  localparam int cDefHActive = 320;
  localparam int cDefVActive = 240;

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int widthOf(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pixel_stream_reader_syncskidbuffer.sv
// Single-clock register FIFO used as the reader's output buffer; head is
// visible combinationally, writes when full and reads when empty are dropped.
module syncSkidBuffer
  import pixel_stream_reader_pkg::*;
#(
  parameter int pWidth = 24,
  parameter int pDepth = 4
) (
  input  logic                             iClk,
  input  logic                             iRst,
  input  logic                             iWrEn,
  input  logic [pWidth-1:0]                iWrData,
  input  logic                             iRdEn,
  output logic [pWidth-1:0]                oRdData,
  output logic                             oFull,
  output logic                             oEmpty,
  output logic [widthOf(pDepth+1)-1:0]     oCount
);

  localparam int cPtrW = widthOf(pDepth);
  localparam int cCntW = widthOf(pDepth + 1);

  logic [pWidth-1:0] mem [pDepth];
  logic [cPtrW-1:0]  wrPtr;
  logic [cPtrW-1:0]  rdPtr;
  logic [cCntW-1:0]  count;
  logic              wrOk;
  logic              rdOk;

  assign oEmpty  = (count == '0);
  assign oFull   = (count == cCntW'(pDepth));
  assign oCount  = count;
  assign oRdData = mem[rdPtr];
  assign wrOk    = iWrEn && !oFull;
  assign rdOk    = iRdEn && !oEmpty;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrOk) wrPtr <= wrPtr + cPtrW'(1);
      if (rdOk) rdPtr <= rdPtr + cPtrW'(1);
      case ({wrOk, rdOk})
        2'b10:   count <= count + cCntW'(1);
        2'b01:   count <= count - cCntW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (wrOk && !iRst) mem[wrPtr] <= iWrData;
  end

endmodule

// File: rtl/pixel_stream_reader.sv
// Reads a frame of pixels from a fixed-latency FIFO into a credit-limited
// buffer and streams it out valid/ready with SOF/EOL/frame-done markers.
module pixel_stream_reader
  import pixel_stream_reader_pkg::*;
#(
  parameter int pBitWidth  = 24,
  parameter int pHActive   = cDefHActive,
  parameter int pVActive   = cDefVActive,
  parameter int pRdLatency = 2,
  parameter int pSkidDepth = 4
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iEnable,
  output logic                 oRE,
  input  logic [pBitWidth-1:0] iRD,
  input  logic                 iRVD,
  input  logic                 iEMP,
  output logic [pBitWidth-1:0] oData,
  output logic                 oValid,
  input  logic                 iReady,
  output logic                 oSof,
  output logic                 oEol,
  output logic                 oFrameDone,
  output logic                 oErr
);

  localparam int cTotal = pHActive * pVActive;
  localparam int cXW    = widthOf(pHActive);
  localparam int cYW    = widthOf(pVActive);
  localparam int cIssW  = widthOf(cTotal + 1);
  localparam int cCntW  = widthOf(pSkidDepth + 1);
  localparam int cLatW  = widthOf(pRdLatency + 1);

  localparam logic [cXW-1:0]   cXLast   = cXW'(pHActive - 1);
  localparam logic [cYW-1:0]   cYLast   = cYW'(pVActive - 1);
  localparam logic [cIssW-1:0] cIssAll  = cIssW'(cTotal);
  localparam logic [cCntW:0]   cCredits = (cCntW + 1)'(pSkidDepth);

  stateT                stateQ;
  stateT                stateD;
  logic [cIssW-1:0]     issuedCnt;
  logic [cCntW-1:0]     inFlight;
  logic [cCntW-1:0]     bufCount;
  logic [cLatW-1:0]     ignoreCnt;
  logic [cXW-1:0]       xCnt;
  logic [cYW-1:0]       yCnt;
  logic [pBitWidth-1:0] bufHead;
  logic [cCntW:0]       credUsed;
  logic                 bufFull;
  logic                 bufEmpty;
  logic                 rdIssue;
  logic                 rvdLive;
  logic                 rvdRet;
  logic                 bufWr;
  logic                 xfer;
  logic                 frameIssued;

  assign frameIssued = (issuedCnt == cIssAll);
  assign credUsed    = {1'b0, bufCount} + {1'b0, inFlight};

  // Returns landing inside the post-reset window belong to reads issued before
  // reset; they are dropped silently rather than flagged.
  assign rvdLive = iRVD && (ignoreCnt == '0);
  assign rvdRet  = rvdLive && (inFlight != '0);
  assign bufWr   = rvdRet && !bufFull;

  always_ff @(posedge iClk) begin
    if (iRst) stateQ <= sIdle;
    else      stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      sIdle:   if (iEnable) stateD = sRun;
      sRun:    if (frameIssued || !iEnable) stateD = sDrain;
      sDrain:  if ((inFlight == '0) && bufEmpty) stateD = sIdle;
      default: stateD = sIdle;
    endcase
  end

  always_comb begin
    rdIssue = 1'b0;
    if ((stateQ == sRun) && !iRst && !iEMP && !frameIssued && (credUsed < cCredits))
      rdIssue = 1'b1;
  end

  assign oRE = rdIssue;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      issuedCnt <= '0;
    end else if ((stateQ == sRun) && frameIssued) begin
      issuedCnt <= '0;
    end else if (rdIssue) begin
      issuedCnt <= issuedCnt + cIssW'(1);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      inFlight <= '0;
    end else begin
      case ({rdIssue, rvdRet})
        2'b10:   inFlight <= inFlight + cCntW'(1);
        2'b01:   inFlight <= inFlight - cCntW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst)                  ignoreCnt <= cLatW'(pRdLatency);
    else if (ignoreCnt != '0)  ignoreCnt <= ignoreCnt - cLatW'(1);
  end

  always_ff @(posedge iClk) begin
    if (iRst)                                      oErr <= 1'b0;
    else if (rvdLive && ((inFlight == '0) || bufFull)) oErr <= 1'b1;
  end

  syncSkidBuffer #(
    .pWidth (pBitWidth),
    .pDepth (pSkidDepth)
  ) uBuf (
    .iClk    (iClk),
    .iRst    (iRst),
    .iWrEn   (bufWr),
    .iWrData (iRD),
    .iRdEn   (xfer),
    .oRdData (bufHead),
    .oFull   (bufFull),
    .oEmpty  (bufEmpty),
    .oCount  (bufCount)
  );

  assign oValid = !bufEmpty;
  assign oData  = bufEmpty ? '0 : bufHead;
  assign xfer   = oValid && iReady;

  // Position survives enable drops so a paused frame resumes where it stopped.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      xCnt <= '0;
      yCnt <= '0;
    end else if (xfer) begin
      if (xCnt == cXLast) begin
        xCnt <= '0;
        yCnt <= (yCnt == cYLast) ? '0 : yCnt + cYW'(1);
      end else begin
        xCnt <= xCnt + cXW'(1);
      end
    end
  end

  assign oSof       = oValid && (xCnt == '0) && (yCnt == '0);
  assign oEol       = oValid && (xCnt == cXLast);
  assign oFrameDone = xfer && (xCnt == cXLast) && (yCnt == cYLast);

endmodule

// File: tb/tb_pixel_stream_reader.sv
// Bench for pixel_stream_reader on a 4x2 frame: a behavioural fixed-latency
// FIFO feeds the reader and a scoreboard queue holds the expected pixels.
module tb_pixel_stream_reader;
  import pixel_stream_reader_pkg::*;

  localparam int W = 24;
  localparam int H = 4;
  localparam int V = 2;
  localparam int L = 2;
  localparam int D = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic         sof;
    logic         eol;
    logic         fd;
  } expT;

  logic         iClk = 1'b0;
  logic         iRst, iEnable, oRE, iRVD, iEMP, oValid, iReady;
  logic         oSof, oEol, oFrameDone, oErr;
  logic [W-1:0] iRD, oData;

  int           total = 0;
  int           bad = 0;
  logic [W-1:0] fifoQ[$];
  expT          expQ[$];
  int           tbX = 0;
  int           tbY = 0;
  logic         dlV[L];
  logic [W-1:0] dlD[L];
  logic         spurious = 1'b0;
  logic [W-1:0] spData = '0;
  int           reads = 0;
  logic         xfer = 1'b0;

  always #5 iClk = ~iClk;

  pixel_stream_reader #(
    .pBitWidth(W), .pHActive(H), .pVActive(V), .pRdLatency(L), .pSkidDepth(D)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iEnable(iEnable), .oRE(oRE), .iRD(iRD),
    .iRVD(iRVD), .iEMP(iEMP), .oData(oData), .oValid(oValid), .iReady(iReady),
    .oSof(oSof), .oEol(oEol), .oFrameDone(oFrameDone), .oErr(oErr)
  );

  task automatic loadWord(input logic [W-1:0] w);
    expT e;
    fifoQ.push_back(w);
    e.data = w;
    e.sof  = (tbX == 0) && (tbY == 0);
    e.eol  = (tbX == H - 1);
    e.fd   = (tbX == H - 1) && (tbY == V - 1);
    expQ.push_back(e);
    if (tbX == H - 1) begin
      tbX = 0;
      tbY = (tbY == V - 1) ? 0 : tbY + 1;
    end else begin
      tbX++;
    end
  endtask

  // One cycle of the FIFO model: drive returns at the falling edge, then
  // capture this cycle's read request once the DUT has settled.
  task automatic tick(input logic rdy);
    @(negedge iClk);
    iReady = rdy;
    iRVD   = dlV[0];
    iRD    = dlV[0] ? dlD[0] : '0;
    for (int i = 0; i < L - 1; i++) begin
      dlV[i] = dlV[i+1];
      dlD[i] = dlD[i+1];
    end
    dlV[L-1] = 1'b0;
    if (spurious) begin
      iRVD = 1'b1;
      iRD = spData;
      spurious = 1'b0;
    end
    iEMP = (fifoQ.size() == 0);
    #1;
    if (oRE && fifoQ.size() != 0) begin
      dlV[L-1] = 1'b1;
      dlD[L-1] = fifoQ.pop_front();
      reads++;
    end
    xfer = oValid && iReady;
  endtask

  task automatic test_reset();
    repeat (3) tick(1'b0);
    total++;
    if ({oRE, oValid, oSof, oEol, oFrameDone, oErr} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000000", {oRE, oValid, oSof, oEol, oFrameDone, oErr});
    end
    total++;
    if (oData !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", oData); end
    iRst = 1'b0;
    repeat (3) tick(1'b0);
    total++;
    if (dut.stateQ !== sIdle || oValid !== 1'b0 || oErr !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: state=%0d valid=%b err=%b want 0 0 0", dut.stateQ, oValid, oErr);
    end
  endtask

  task automatic test_basic();
    expT e;
    int cyc = 0;
    iEnable = 1'b1;
    for (int k = 1; k <= 8; k++) loadWord(W'(k));
    while (expQ.size() != 0 && cyc < 200) begin
      tick(1'b1);
      cyc++;
      if (xfer) begin
        total++;
        e = expQ.pop_front();
        if ({oData, oSof, oEol, oFrameDone} !== e) begin
          bad++;
          $display("FAIL basic_pixel: got %h s%b e%b f%b want %h s%b e%b f%b",
                   oData, oSof, oEol, oFrameDone, e.data, e.sof, e.eol, e.fd);
        end
      end
    end
    total++;
    if (expQ.size() != 0) begin bad++; $display("FAIL basic_timeout: %0d pixels left, want 0", expQ.size()); end
  endtask

  task automatic test_backpressure();
    expT e;
    int cyc = 0;
    int occ;
    for (int k = 9; k <= 16; k++) loadWord(W'(k));
    while (expQ.size() != 0 && cyc < 300) begin
      tick((cyc % 4 == 0) || (cyc % 4 == 3));
      cyc++;
      occ = int'(dut.inFlight) + int'(dut.bufCount);
      total++;
      if (occ > D) begin bad++; $display("FAIL bp_credit: inflight+occupancy=%0d want <=%0d", occ, D); end
      if (xfer) begin
        total++;
        e = expQ.pop_front();
        if ({oData, oSof, oEol, oFrameDone} !== e) begin
          bad++;
          $display("FAIL bp_pixel: got %h s%b e%b f%b want %h s%b e%b f%b",
                   oData, oSof, oEol, oFrameDone, e.data, e.sof, e.eol, e.fd);
        end
      end
    end
    total++;
    if (expQ.size() != 0) begin bad++; $display("FAIL bp_timeout: %0d pixels left, want 0", expQ.size()); end
  endtask

  task automatic test_empty();
    expT e;
    int cyc = 0;
    int readsBefore;
    for (int k = 17; k <= 19; k++) loadWord(W'(k));
    for (int phase = 0; phase < 2; phase++) begin
      cyc = 0;
      while (expQ.size() != 0 && cyc < 200) begin
        tick(1'b1);
        cyc++;
        if (xfer) begin
          total++;
          e = expQ.pop_front();
          if ({oData, oSof, oEol, oFrameDone} !== e) begin
            bad++;
            $display("FAIL empty_pixel: got %h s%b e%b f%b want %h s%b e%b f%b",
                     oData, oSof, oEol, oFrameDone, e.data, e.sof, e.eol, e.fd);
          end
        end
      end
      total++;
      if (expQ.size() != 0) begin bad++; $display("FAIL empty_timeout: %0d pixels left, want 0", expQ.size()); end
      if (phase == 0) begin
        readsBefore = reads;
        for (int c = 0; c < 5; c++) begin
          tick(1'b1);
          total++;
          if (oRE !== 1'b0 || oValid !== 1'b0) begin
            bad++;
            $display("FAIL empty_hold: re=%b valid=%b want 0 0", oRE, oValid);
          end
        end
        total++;
        if (reads != readsBefore) begin bad++; $display("FAIL empty_reads: got %0d want %0d", reads, readsBefore); end
        for (int k = 20; k <= 24; k++) loadWord(W'(k));
      end
    end
  endtask

  task automatic test_enable_drop();
    expT e;
    int cyc = 0;
    reads = 0;
    for (int k = 25; k <= 32; k++) loadWord(W'(k));
    while (!(expQ.size() == 3 && dut.stateQ == sIdle) && cyc < 200) begin
      tick(1'b1);
      cyc++;
      if (reads == 5) iEnable = 1'b0;
      if (xfer) begin
        total++;
        e = expQ.pop_front();
        if ({oData, oSof, oEol, oFrameDone} !== e) begin
          bad++;
          $display("FAIL drop_pixel: got %h s%b e%b f%b want %h s%b e%b f%b",
                   oData, oSof, oEol, oFrameDone, e.data, e.sof, e.eol, e.fd);
        end
      end
    end
    total++;
    if (reads != 5 || expQ.size() != 3) begin
      bad++;
      $display("FAIL drop_count: reads=%0d left=%0d want 5 3", reads, expQ.size());
    end
    total++;
    if (dut.stateQ !== sIdle) begin bad++; $display("FAIL drop_state: got %0d want %0d", dut.stateQ, sIdle); end
    iEnable = 1'b1;
    cyc = 0;
    while (expQ.size() != 0 && cyc < 200) begin
      tick(1'b1);
      cyc++;
      if (xfer) begin
        if (expQ.size() == 3) begin
          total++;
          if (dut.xCnt !== 1 || dut.yCnt !== 1) begin
            bad++;
            $display("FAIL drop_resume: x=%0d y=%0d want 1 1", dut.xCnt, dut.yCnt);
          end
        end
        total++;
        e = expQ.pop_front();
        if ({oData, oSof, oEol, oFrameDone} !== e) begin
          bad++;
          $display("FAIL drop_pixel2: got %h s%b e%b f%b want %h s%b e%b f%b",
                   oData, oSof, oEol, oFrameDone, e.data, e.sof, e.eol, e.fd);
        end
      end
    end
    total++;
    if (expQ.size() != 0) begin bad++; $display("FAIL drop_timeout: %0d pixels left, want 0", expQ.size()); end
  endtask

  task automatic test_spurious();
    iEnable = 1'b0;
    repeat (4) tick(1'b1);
    total++;
    if (oErr !== 1'b0) begin bad++; $display("FAIL spur_pre: err=%b want 0", oErr); end
    spData = 24'hABCDEF;
    spurious = 1'b1;
    tick(1'b1);
    tick(1'b1);
    total++;
    if (oErr !== 1'b1 || oValid !== 1'b0) begin
      bad++;
      $display("FAIL spur_flag: err=%b valid=%b want 1 0", oErr, oValid);
    end
    repeat (5) tick(1'b1);
    total++;
    if (oErr !== 1'b1 || oValid !== 1'b0) begin
      bad++;
      $display("FAIL spur_hold: err=%b valid=%b want 1 0", oErr, oValid);
    end
  endtask

  task automatic test_reset_inflight();
    int cyc = 0;
    iEnable = 1'b1;
    for (int k = 100; k < 108; k++) fifoQ.push_back(W'(k));
    while (dut.inFlight != 2 && cyc < 50) begin
      tick(1'b0);
      cyc++;
    end
    total++;
    if (dut.inFlight != 2) begin bad++; $display("FAIL rst_setup: inflight=%0d want 2", dut.inFlight); end
    iRst = 1'b1;
    iEnable = 1'b0;
    tick(1'b1);
    total++;
    if ({oRE, oValid, oSof, oEol, oFrameDone, oErr} !== 6'b0 || oData !== '0 || dut.stateQ !== sIdle) begin
      bad++;
      $display("FAIL rst_outputs: flags=%b data=%h state=%0d want 000000 0 0",
               {oRE, oValid, oSof, oEol, oFrameDone, oErr}, oData, dut.stateQ);
    end
    iRst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(1'b1);
      total++;
      if (oErr !== 1'b0 || oValid !== 1'b0) begin
        bad++;
        $display("FAIL rst_late: err=%b valid=%b want 0 0", oErr, oValid);
      end
    end
    fifoQ.delete();
  endtask

  initial begin
    for (int i = 0; i < L; i++) begin
      dlV[i] = 1'b0;
      dlD[i] = '0;
    end
    iRst = 1'b1;
    iEnable = 1'b0;
    iReady = 1'b0;
    iRVD = 1'b0;
    iRD = '0;
    iEMP = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_empty();
    test_enable_drop();
    test_spurious();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
